// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Two-flop synchroniser on the serial line, start-bit validation at mid-bit,
// mid-bit sampling of 8 data bits (LSB first) and the stop bit, a registered
// one-cycle o_valid strobe for good frames and a registered one-cycle
// o_frame_err strobe when the stop bit is sampled low. After a framing error
// the receiver parks in BREAK until the line returns high, so a held-low line
// is not read as a stream of 0x00 bytes.
module uart_rx #(
  parameter logic [23:0] CLKS_PER_BAUD = 24'd868  // i_clk cycles per bit, >= 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  // One extra bit of headroom over the largest value ever loaded.
  localparam int CNT_W = $clog2(CLKS_PER_BAUD) + 1;

  // Reload values. The first reload lands the start-bit sample at mid-bit;
  // every later reload spaces samples one full bit period apart.
  localparam logic [23:0] HALF_M1 = (CLKS_PER_BAUD / 24'd2) - 24'd1;
  localparam logic [23:0] FULL_M1 = CLKS_PER_BAUD - 24'd1;
  localparam logic [CNT_W-1:0] HALF_RELOAD = HALF_M1[CNT_W-1:0];
  localparam logic [CNT_W-1:0] FULL_RELOAD = FULL_M1[CNT_W-1:0];

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t           state_q;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             sample;

  // The counter hitting zero marks the mid-bit sample point.
  assign sample = (cnt_q == '0);

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM with baud counter, bit index, shift register and
  // registered output strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            cnt_q   <= HALF_RELOAD;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (sample) begin
            if (rx_s_q) begin
              // Line went back high before mid-start: treat as a glitch.
              state_q <= ST_IDLE;
            end else begin
              cnt_q     <= FULL_RELOAD;
              bit_idx_q <= '0;
              state_q   <= ST_DATA;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_DATA: begin
          if (sample) begin
            // LSB arrives first, so shifting right leaves it in bit 0.
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            cnt_q     <= FULL_RELOAD;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_STOP: begin
          if (sample) begin
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              // Leaving at mid-stop lets a back-to-back start edge be seen.
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_BREAK: begin
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx at 32 clocks per bit. Stimulus
// pushes the expected strobe (good byte or framing error) into a scoreboard;
// a separate monitor pops and compares whenever the DUT raises a strobe.
module tb_uart_rx;

  logic       i_clk;
  logic       i_rst;
  logic       i_uart_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BAUD(24'd32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end else begin
      $display("ok   %s value=%02h", name, act);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_strobes actual=%0d expected=0", name, sb.size());
    end else begin
      $display("ok   %s scoreboard empty", name);
    end
  endtask

  task automatic idle(input int n);
    i_uart_rx = 1'b1;
    repeat (n) @(negedge i_clk);
  endtask

  // Sends one frame; rst_bit >= 0 pulses reset in the middle of that bit
  // period (0 = start, k+1 = data bit k) and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input int period,
                            input bit stop_val, input int rst_bit);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop_val, data, 1'b0};
    if (rst_bit < 0) begin
      e.is_err = !stop_val;
      e.data   = stop_val ? data : last_good;
      sb.push_back(e);
      if (stop_val) last_good = data;
    end
    for (int b = 0; b < 10; b++) begin
      i_uart_rx = bits[b];
      if (b == rst_bit) begin
        repeat (period / 2) @(negedge i_clk);
        i_rst     = 1'b1;
        i_uart_rx = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_val("rst_mid_busy", {7'd0, o_busy}, 8'h00);
        check_val("rst_mid_data", o_data, 8'h00);
        check_val("rst_mid_strobe", {6'd0, o_valid, o_frame_err}, 8'h00);
        last_good = 8'h00;
        return;
      end
      repeat (period) @(negedge i_clk);
    end
  endtask

  // Monitor: one line per strobe, compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_valid || o_frame_err) begin
        checks++;
        if (o_valid && o_frame_err) begin
          errors++;
          $display("FAIL strobe_overlap valid=%0b frame_err=%0b required one-hot", o_valid, o_frame_err);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe valid=%0b frame_err=%0b data=%02h required none",
                   o_valid, o_frame_err, o_data);
        end else begin
          e = sb.pop_front();
          if (e.is_err != o_frame_err || o_data !== e.data) begin
            errors++;
            $display("FAIL rx_strobe frame_err=%0b data=%02h expected frame_err=%0b data=%02h",
                     o_frame_err, o_data, e.is_err, e.data);
          end else begin
            $display("ok   rx_strobe frame_err=%0b data=%02h", o_frame_err, o_data);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst     = 1'b1;
    i_uart_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    check_val("reset_busy", {7'd0, o_busy}, 8'h00);
    check_val("reset_valid", {7'd0, o_valid}, 8'h00);
    check_val("reset_frame_err", {7'd0, o_frame_err}, 8'h00);
    check_val("reset_data", o_data, 8'h00);
    i_rst = 1'b0;
    idle(10);

    // 1: single frame
    send_frame(8'h55, 32, 1'b1, -1);
    check_val("t1_busy_after_stop", {7'd0, o_busy}, 8'h00);
    idle(8);
    check_drained("t1_drained");

    // 2: back-to-back, no idle gap
    send_frame(8'hA5, 32, 1'b1, -1);
    send_frame(8'h3C, 32, 1'b1, -1);
    idle(8);
    check_drained("t2_drained");

    // 3: 8-cycle glitch then a real frame
    i_uart_rx = 1'b0;
    repeat (8) @(negedge i_clk);
    check_val("t3_busy_in_glitch", {7'd0, o_busy}, 8'h01);
    i_uart_rx = 1'b1;
    repeat (16) @(negedge i_clk);
    check_val("t3_busy_after_glitch", {7'd0, o_busy}, 8'h00);
    idle(16);
    send_frame(8'h81, 32, 1'b1, -1);
    idle(8);
    check_drained("t3_drained");

    // 4: framing error then break held low
    send_frame(8'hF0, 32, 1'b0, -1);
    i_uart_rx = 1'b0;
    repeat (128) @(negedge i_clk);
    check_val("t4_busy_in_break", {7'd0, o_busy}, 8'h01);
    check_val("t4_data_kept", o_data, 8'h81);
    idle(8);
    check_val("t4_busy_after_break", {7'd0, o_busy}, 8'h00);
    send_frame(8'h12, 32, 1'b1, -1);
    idle(8);
    check_drained("t4_drained");

    // 5: reset during data bit 4
    send_frame(8'h99, 32, 1'b1, 5);
    idle(40);
    send_frame(8'hC3, 32, 1'b1, -1);
    idle(8);
    check_drained("t5_drained");

    // 6: bit-period tolerance
    send_frame(8'h69, 31, 1'b1, -1);
    idle(32);
    send_frame(8'h69, 33, 1'b1, -1);
    idle(20);
    check_drained("final_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity), matching the framing of the team's UART transmitter. It synchronises the asynchronous serial line, detects the start bit, samples each bit at mid-period from a per-bit counter, and presents each received byte with a one-cycle valid strobe. Framing errors are flagged. It sits between the external RX pin and the byte-level consumer, typically a FIFO or command parser.

Parameters:
CLKS_PER_BAUD, 24'd868, i_clk cycles per bit (100 MHz / 115200 baud); must be >= 4.

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_uart_rx  input  1  asynchronous serial line, idle high
o_data  output  8  last correctly framed byte; holds until the next good frame
o_valid  output  1  one-cycle strobe: o_data updated this cycle
o_frame_err  output  1  one-cycle strobe: stop bit sampled low
o_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (i_rst high at a posedge): the FSM goes to IDLE. Both synchroniser flops are set to 1. o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0. The bit index and baud counter are cleared. Reset mid-frame discards the partial byte, with no strobe.
- Synchroniser: i_uart_rx passes through 2 flops. All FSM decisions use the second flop (rx_s).
- Baud counter: width $clog2(CLKS_PER_BAUD)+1. It decrements each cycle while the FSM is not in IDLE or BREAK. A "sample" event occurs in the cycle the counter is 0. The counter reloads on state entry as listed below.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: if rx_s==0, load counter with CLKS_PER_BAUD/2 - 1 and go to START.
  - START: on sample, if rx_s==1 the start bit was a glitch: go to IDLE with no strobe. Otherwise load CLKS_PER_BAUD-1, set bit index to 0 and go to DATA.
  - DATA: on sample, shift rx_s into the MSB of the shift register (shift right) and increment the bit index. After the 8th bit (index 7), load CLKS_PER_BAUD-1 and go to STOP. Otherwise reload CLKS_PER_BAUD-1 and stay in DATA.
  - STOP, on sample with rx_s==1: next cycle o_data <= shift register and o_valid=1 for exactly one cycle. Go to IDLE.
  - STOP, on sample with rx_s==0: next cycle o_frame_err=1 for exactly one cycle. o_valid stays 0 and o_data is unchanged. Go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from being read as repeated 0x00 frames.
- Strobes are registered. o_valid and o_frame_err are never high in the same cycle. Both are 0 in all other cycles.
- Timing:
  - All samples land at mid-bit: bit n is sampled CLKS_PER_BAUD/2 + n*CLKS_PER_BAUD cycles after the start edge is seen on rx_s, where n=0 is the start bit and n=9 is the stop bit.
  - o_valid rises 1 cycle after the stop sample, i.e. about 9.5 bit periods plus 3 cycles after the falling edge on the pin.
- Back-to-back frames: the FSM returns to IDLE at mid-stop-bit. A start edge arriving right after the stop bit (no idle gap) must be caught with no frame dropped.
- Tolerance: frames must be received correctly with a TX bit-period error up to ±3%.
- o_busy = (state != IDLE). It is combinational from the state register.

Test Plan:
(All scenarios use CLKS_PER_BAUD=32.)
1. Single frame 0x55 at a 32-cycle bit period -> one o_valid pulse, o_data=0x55, o_frame_err never high, o_busy falls to 0 after the stop sample.
2. Back-to-back frames 0xA5 then 0x3C with no idle gap -> exactly two o_valid pulses, carrying 0xA5 then 0x3C, in order.
3. Glitch: line low for 8 cycles, then high -> no strobes, o_busy high for about 16 cycles then 0. A following frame 0x81 is received correctly.
4. Frame 0xF0 with stop bit driven 0, then line held low 128 cycles -> one o_frame_err pulse. o_valid stays 0 and o_data keeps its previous value. o_busy stays 1 (BREAK) until the line goes high. A following frame 0x12 is received correctly.
5. i_rst pulsed during data bit 4 of frame 0x99 -> the cycle after reset o_busy=0, o_data=0x00, no strobe for that frame. A following frame 0xC3 is received correctly.
6. Frame 0x69 sent with 31-cycle and then 33-cycle bit periods -> both give o_valid with o_data=0x69 and no o_frame_err.
